// File: rtl/axi_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : axi_pwm_bank
//  Purpose  : AXI4-Lite controlled bank of edge-aligned PWM outputs sharing
//             one period counter. The period and the prescaler are
//             programmable. Each channel has its own output enable. Duty and
//             period writes land in shadow registers and are copied to the
//             active set at counter wrap, so an output never glitches mid-period.
//  Ports    : S_AXI_ACLK / S_AXI_ARESETN  - clock, synchronous active-low reset
//             S_AXI_AW* / W* / B*         - AXI4-Lite write address/data/resp
//             S_AXI_AR* / R*              - AXI4-Lite read address/data
//             PWM[C_NUM_PWM]              - registered PWM outputs
//             PWM_OEB[C_NUM_PWM]          - active-low output enables
//  Register map (byte offsets):
//             0x000 ID     RO  0x5057_4D02
//             0x004 CTRL   RW  [0] ENABLE, [15:8] PRESCALE
//             0x008 PERIOD RW  shadow period (reads return shadow)
//             0x00C COUNT  RO  current counter value
//             0x100+4n DUTYn RW [W-1:0] duty shadow, [31] OE (immediate)
//  Revision : 1.0  initial release
// ============================================================================
module axi_pwm_bank #(
    parameter int C_NUM_PWM    = 1,
    parameter int C_PWM_WIDTH  = 24,
    parameter int C_ADDR_WIDTH = 10
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [C_NUM_PWM-1:0]    PWM,
    output logic [C_NUM_PWM-1:0]    PWM_OEB
);

    localparam int          c_W           = C_PWM_WIDTH;
    localparam logic [31:0] c_ID          = 32'h5057_4D02;
    localparam logic [29:0] c_WORD_ID     = 30'h000;
    localparam logic [29:0] c_WORD_CTRL   = 30'h001;
    localparam logic [29:0] c_WORD_PERIOD = 30'h002;
    localparam logic [29:0] c_WORD_COUNT  = 30'h003;
    localparam logic [29:0] c_WORD_DUTY0  = 30'h040;

    logic clk;
    assign clk = S_AXI_ACLK;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                              awready_q, awready_d;
    logic                              bvalid_q,  bvalid_d;
    logic                              arready_q, arready_d;
    logic                              rvalid_q,  rvalid_d;
    logic [31:0]                       rdata_q,   rdata_d;

    logic                              ctrl_en_q,    ctrl_en_d;
    logic [7:0]                        prescale_q,   prescale_d;
    logic [c_W-1:0]                    period_sh_q,  period_sh_d;
    logic [c_W-1:0]                    period_act_q, period_act_d;
    logic [C_NUM_PWM-1:0][c_W-1:0]     duty_sh_q,    duty_sh_d;
    logic [C_NUM_PWM-1:0][c_W-1:0]     duty_act_q,   duty_act_d;
    logic [C_NUM_PWM-1:0]              oe_q,         oe_d;
    logic [c_W-1:0]                    counter_q,    counter_d;
    logic [7:0]                        pscnt_q,      pscnt_d;
    logic [C_NUM_PWM-1:0]              pwm_q,        pwm_d;
    logic [C_NUM_PWM-1:0]              oeb_q,        oeb_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_wr_fire;
    logic        w_rd_fire;
    logic        w_ctrl_wr;
    logic        w_tick;
    logic        w_wrap;
    logic [29:0] w_wr_word;
    logic [29:0] w_rd_word;
    logic [31:0] w_rd_val;
    logic        w_unused;

    // Byte address to word index; the two low address bits are ignored.
    assign w_wr_word = 30'(S_AXI_AWADDR >> 2);
    assign w_rd_word = 30'(S_AXI_ARADDR >> 2);

    // Only part of the write data word is meaningful for any register.
    assign w_unused = ^S_AXI_WDATA;

    // The ready pulse is only raised when both AW and W are valid, and the
    // master holds them until it sees ready, so the edge on which ready is
    // high is the edge on which the register is written.
    assign w_wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_fire = arready_q & S_AXI_ARVALID;

    assign w_tick = (pscnt_q == prescale_q);

    // ------------------------------------------------------------------
    // AXI handshake next-state
    // ------------------------------------------------------------------
    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;

        bvalid_d = bvalid_q;
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (w_wr_fire) begin
            bvalid_d = 1'b1;
        end

        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (w_rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rd_val;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (register state before any same-edge write)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        if (w_rd_word == c_WORD_ID) begin
            w_rd_val = c_ID;
        end else if (w_rd_word == c_WORD_CTRL) begin
            w_rd_val[0]    = ctrl_en_q;
            w_rd_val[15:8] = prescale_q;
        end else if (w_rd_word == c_WORD_PERIOD) begin
            w_rd_val[c_W-1:0] = period_sh_q;
        end else if (w_rd_word == c_WORD_COUNT) begin
            w_rd_val[c_W-1:0] = counter_q;
        end
        for (int n = 0; n < C_NUM_PWM; n++) begin
            if (w_rd_word == c_WORD_DUTY0 + 30'(n)) begin
                w_rd_val[c_W-1:0] = duty_sh_q[n];
                w_rd_val[31]      = oe_q[n];
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file writes
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        prescale_d  = prescale_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        oe_d        = oe_q;
        w_ctrl_wr   = 1'b0;
        if (w_wr_fire) begin
            if (w_wr_word == c_WORD_CTRL) begin
                ctrl_en_d  = S_AXI_WDATA[0];
                prescale_d = S_AXI_WDATA[15:8];
                w_ctrl_wr  = 1'b1;
            end else if (w_wr_word == c_WORD_PERIOD) begin
                period_sh_d = S_AXI_WDATA[c_W-1:0];
            end
            for (int n = 0; n < C_NUM_PWM; n++) begin
                if (w_wr_word == c_WORD_DUTY0 + 30'(n)) begin
                    duty_sh_d[n] = S_AXI_WDATA[c_W-1:0];
                    oe_d[n]      = S_AXI_WDATA[31];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler, period counter and shadow transfer
    // ------------------------------------------------------------------
    always_comb begin
        pscnt_d   = pscnt_q;
        counter_d = counter_q;
        w_wrap    = 1'b0;
        if (!ctrl_en_q) begin
            pscnt_d   = '0;
            counter_d = '0;
        end else begin
            pscnt_d = w_tick ? 8'd0 : pscnt_q + 8'd1;
            if (w_tick) begin
                if (counter_q == period_act_q) begin
                    counter_d = '0;
                    w_wrap    = 1'b1;
                end else begin
                    counter_d = counter_q + c_W'(1);
                end
            end
        end
        // A new PRESCALE value must not be compared against a stale count.
        if (w_ctrl_wr) begin
            pscnt_d = '0;
        end
    end

    // The active set is loaded from the *next* shadow value so a write on
    // the wrap edge is captured by that same wrap.
    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!ctrl_en_q || w_wrap) begin
            period_act_d = period_sh_d;
            duty_act_d   = duty_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: one registered stage after the counter / OE register
    // ------------------------------------------------------------------
    always_comb begin
        for (int n = 0; n < C_NUM_PWM; n++) begin
            pwm_d[n] = ctrl_en_q & (counter_q < duty_act_q[n]);
        end
        oeb_d = ~oe_q;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!S_AXI_ARESETN) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            ctrl_en_q    <= 1'b0;
            prescale_q   <= '0;
            period_sh_q  <= '1;
            period_act_q <= '1;
            duty_sh_q    <= '0;
            duty_act_q   <= '0;
            oe_q         <= '0;
            counter_q    <= '0;
            pscnt_q      <= '0;
            pwm_q        <= '0;
            oeb_q        <= '1;
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            ctrl_en_q    <= ctrl_en_d;
            prescale_q   <= prescale_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            duty_sh_q    <= duty_sh_d;
            duty_act_q   <= duty_act_d;
            oe_q         <= oe_d;
            counter_q    <= counter_d;
            pscnt_q      <= pscnt_d;
            pwm_q        <= pwm_d;
            oeb_q        <= oeb_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign PWM           = pwm_q;
    assign PWM_OEB       = oeb_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_pwm_bank
//  Purpose  : Directed self-checking bench for axi_pwm_bank (1 channel,
//             24-bit counter). PWM[0] is sampled every falling edge into a
//             history buffer so waveform shapes can be compared exactly.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_pwm_bank;

    localparam int          c_NUM = 1;
    localparam int          c_W   = 24;
    localparam int          c_AW  = 10;
    localparam logic [31:0] c_ID  = 32'h5057_4D02;

    logic             clk = 1'b0;
    logic             rstn;
    logic [c_AW-1:0]  awaddr;
    logic             awvalid;
    logic             awready;
    logic [31:0]      wdata;
    logic             wvalid;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    logic [c_AW-1:0]  araddr;
    logic             arvalid;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;
    logic [c_NUM-1:0] pwm;
    logic [c_NUM-1:0] pwm_oeb;

    int checks = 0;
    int errors = 0;

    logic hist [0:4095];
    int   cyc = 0;

    always #5 clk = ~clk;

    axi_pwm_bank #(
        .C_NUM_PWM   (c_NUM),
        .C_PWM_WIDTH (c_W),
        .C_ADDR_WIDTH(c_AW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .PWM          (pwm),
        .PWM_OEB      (pwm_oeb)
    );

    always @(negedge clk) begin
        hist[cyc % 4096] = pwm[0];
        cyc = cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             output logic [1:0] resp);
        int n;
        awaddr  = a[c_AW-1:0];
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            step(1);
            n++;
        end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL write_awready_timeout addr=%h got=0 want=1", a);
        end
        step(1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            step(1);
            n++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_bvalid_timeout addr=%h got=0 want=1", a);
        end
        resp   = bresp;
        bready = 1'b1;
        step(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        araddr  = a[c_AW-1:0];
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            step(1);
            n++;
        end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL read_arready_timeout addr=%h got=0 want=1", a);
        end
        step(1);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            step(1);
            n++;
        end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_rvalid_timeout addr=%h got=0 want=1", a);
        end
        d      = rdata;
        resp   = rresp;
        rready = 1'b1;
        step(1);
        rready = 1'b0;
    endtask

    // Returns the history index of the first sample where PWM[0] went 0->1.
    task automatic find_rise(output int r);
        logic prev;
        r    = -1;
        prev = pwm[0];
        for (int n = 0; n < 80; n++) begin
            step(1);
            if (pwm[0] && !prev) begin
                r = cyc;
                break;
            end
            prev = pwm[0];
        end
        if (r < 0) begin
            checks++; errors++;
            $display("FAIL find_rise_timeout got=none want=rising edge");
            r = cyc;
        end
    endtask

    task automatic wait_hist(input int last);
        int n;
        n = 0;
        while (cyc <= last && n < 200) begin
            step(1);
            n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  rr;
        logic        stable;
        int          n;
        rstn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; awaddr = '0; araddr = '0; wdata = '0;
        step(3);
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got=%b want=00000",
                     {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got=%h/%b/%b want=0/00/00", rdata, bresp, rresp);
        end
        checks++;
        if (pwm !== 1'b0 || pwm_oeb !== 1'b1) begin
            errors++;
            $display("FAIL reset_pwm got=%b/%b want=0/1", pwm, pwm_oeb);
        end
        rstn = 1'b1;
        step(1);

        // ID read with RREADY held low for five cycles
        araddr  = '0;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            step(1);
            n++;
        end
        step(1);
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== c_ID || rresp !== 2'b00) begin
            errors++;
            $display("FAIL id_read got=%b/%h/%b want=1/%h/00", rvalid, rdata, rresp, c_ID);
        end
        stable = 1'b1;
        repeat (5) begin
            step(1);
            if (rvalid !== 1'b1 || rdata !== c_ID || arready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL id_hold got=unstable rvalid=%b rdata=%h want=stable", rvalid, rdata);
        end
        rready = 1'b1;
        step(1);
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL id_release got=%b want=0", rvalid);
        end

        axi_read(32'h008, d, rr);
        checks++;
        if (d !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL reset_period got=%h want=00ffffff", d);
        end
        axi_read(32'h004, d, rr);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%h want=00000000", d);
        end
        axi_read(32'h00C, d, rr);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_count got=%h want=00000000", d);
        end
    endtask

    task automatic test_regmap;
        logic [31:0] d;
        logic [1:0]  rr;
        logic [1:0]  br;
        axi_write(32'h000, 32'hFFFF_FFFF, br);
        checks++;
        if (br !== 2'b00) begin
            errors++;
            $display("FAIL ro_write_bresp got=%b want=00", br);
        end
        axi_read(32'h000, d, rr);
        checks++;
        if (d !== c_ID) begin
            errors++;
            $display("FAIL ro_write_ignored got=%h want=%h", d, c_ID);
        end
        axi_write(32'h010, 32'h1234_5678, br);
        axi_read(32'h010, d, rr);
        checks++;
        if (d !== 32'h0 || rr !== 2'b00) begin
            errors++;
            $display("FAIL unmapped_read got=%h/%b want=00000000/00", d, rr);
        end
        axi_read(32'h104, d, rr);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL duty1_absent got=%h want=00000000", d);
        end
    endtask

    task automatic test_basic_pwm;
        logic [31:0] d;
        logic [1:0]  rr;
        logic [1:0]  br;
        logic [29:0] got, exp;
        int          r;
        axi_write(32'h008, 32'd9, br);
        axi_read(32'h008, d, rr);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL period_readback got=%h want=00000009", d);
        end
        axi_write(32'h100, 32'h8000_0003, br);
        step(2);
        checks++;
        if (pwm_oeb !== 1'b0 || pwm !== 1'b0) begin
            errors++;
            $display("FAIL oe_enable got=oeb%b pwm%b want=oeb0 pwm0", pwm_oeb, pwm);
        end
        axi_read(32'h100, d, rr);
        checks++;
        if (d !== 32'h8000_0003) begin
            errors++;
            $display("FAIL duty_readback got=%h want=80000003", d);
        end
        axi_write(32'h004, 32'h0000_0001, br);
        step(5);
        find_rise(r);
        wait_hist(r + 29);
        for (int i = 0; i < 30; i++) begin
            got[i] = hist[(r + i) % 4096];
            exp[i] = ((i % 10) < 3);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL duty3_period10 got=%b want=%b", got, exp);
        end
    endtask

    task automatic test_duty_update;
        logic [1:0]  br;
        logic [24:0] got, exp;
        int          r;
        find_rise(r);
        axi_write(32'h100, 32'h8000_0007, br);
        wait_hist(r + 24);
        for (int i = 0; i < 25; i++) begin
            got[i] = hist[(r + i) % 4096];
            exp[i] = (i < 10) ? (i < 3) : (((i - 10) % 10) < 7);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL duty_shadow_switch got=%b want=%b", got, exp);
        end
    endtask

    task automatic test_duty_limits;
        logic [1:0]  br;
        logic [29:0] got;
        int          r;
        axi_write(32'h100, 32'h8000_0000, br);
        step(25);
        r = cyc;
        wait_hist(r + 29);
        for (int i = 0; i < 30; i++) got[i] = hist[(r + i) % 4096];
        checks++;
        if (got !== 30'h0) begin
            errors++;
            $display("FAIL duty0_const_low got=%b want=all 0", got);
        end
        axi_write(32'h100, 32'h8000_000A, br);
        step(12);
        r = cyc;
        wait_hist(r + 29);
        for (int i = 0; i < 30; i++) got[i] = hist[(r + i) % 4096];
        checks++;
        if (got !== 30'h3FFF_FFFF) begin
            errors++;
            $display("FAIL duty_over_period_const_high got=%b want=all 1", got);
        end
    endtask

    task automatic test_prescale;
        logic [31:0] d;
        logic [1:0]  rr;
        logic [1:0]  br;
        logic [39:0] got, exp;
        int          r, early, awc, wc, bc, both;
        logic        drop;
        // AW presented three cycles ahead of W
        awaddr  = 10'h008;
        wdata   = 32'd4;
        awvalid = 1'b1;
        bready  = 1'b1;
        early   = 0;
        repeat (3) begin
            step(1);
            if (awready || wready || bvalid) early++;
        end
        wvalid = 1'b1;
        awc = 0; wc = 0; bc = 0; both = 0; drop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (drop) begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
                drop    = 1'b0;
            end
            if (awready) begin
                awc++;
                drop = 1'b1;
            end
            if (wready) wc++;
            if (awready && wready) both++;
            if (bvalid) bc++;
        end
        bready = 1'b0;
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL aw_only_waits got=%0d want=0", early);
        end
        checks++;
        if (awc !== 1 || wc !== 1 || both !== 1 || bc !== 1) begin
            errors++;
            $display("FAIL split_write_pulses got=aw%0d w%0d both%0d b%0d want=1 1 1 1",
                     awc, wc, both, bc);
        end
        axi_write(32'h100, 32'h8000_0002, br);
        axi_write(32'h004, 32'h0000_0301, br);
        axi_read(32'h004, d, rr);
        checks++;
        if (d !== 32'h0000_0301) begin
            errors++;
            $display("FAIL ctrl_readback got=%h want=00000301", d);
        end
        step(60);
        find_rise(r);
        wait_hist(r + 39);
        for (int i = 0; i < 40; i++) begin
            got[i] = hist[(r + i) % 4096];
            exp[i] = ((i % 20) < 8);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL prescale3_period4_duty2 got=%b want=%b", got, exp);
        end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] d;
        logic [1:0]  rr;
        int          r, n;
        find_rise(r);
        step(1);
        checks++;
        if (pwm !== 1'b1) begin
            errors++;
            $display("FAIL running_high got=%b want=1", pwm);
        end
        awaddr  = 10'h008;
        wdata   = 32'd7;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b0;
        n = 0;
        while (!awready && n < 20) begin
            step(1);
            n++;
        end
        step(1);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        step(1);
        checks++;
        if (bvalid !== 1'b1 || pwm !== 1'b1) begin
            errors++;
            $display("FAIL bvalid_pending got=b%b pwm%b want=b1 pwm1", bvalid, pwm);
        end
        rstn = 1'b0;
        step(1);
        checks++;
        if (bvalid !== 1'b0 || pwm !== 1'b0 || pwm_oeb !== 1'b1) begin
            errors++;
            $display("FAIL midflight_reset got=b%b pwm%b oeb%b want=b0 pwm0 oeb1",
                     bvalid, pwm, pwm_oeb);
        end
        rstn = 1'b1;
        step(1);
        axi_read(32'h008, d, rr);
        checks++;
        if (d !== 32'h00FF_FFFF) begin
            errors++;
            $display("FAIL period_after_reset got=%h want=00ffffff", d);
        end
        axi_read(32'h100, d, rr);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL duty_after_reset got=%h want=00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_regmap();
        test_basic_pwm();
        test_duty_update();
        test_duty_limits();
        test_prescale();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
